tenyr_mem_responder: RTL and testbench
======================================

Name: tenyr_mem_responder

Overview:
- Memory target on the far side of the core's bus: answers instruction fetches (insn_addr/insn_data) and data accesses (rw/norm_addr/norm_data).
- Sits beside Core at the top level, holding a DEPTH-word RAM window at BASE.
- After reset it runs a hardware clear sequence before accepting accesses.
- It counts stray writes that fall outside its window.

Parameters:
BASE, 32'h00001000, word address of first RAM word; must be DEPTH-aligned and nonzero, so the idle bus address 0 never hits
DEPTH, 1024, number of 32-bit words; power of two, 16..65536
AW, log2(DEPTH), internal index width (derived, not overridable)

Ports:
clk  input  1  system clock; all state changes on posedge
reset_n  input  1  asynchronous, active-low reset
en  input  1  global enable; when 0 all state (RAM, counters, FSM, registered outputs) holds
insn_addr  input  32  fetch word address from Core
insn_data  output  32  registered fetch data
rw  input  1  data direction from Core: 1 = write (Core drives norm_data), 0 = read
norm_addr  input  32  data word address from Core; 0 when Core idle
norm_data  inout  32  data bus; driven by this block only on a read hit, else 32'bz
ready  output  1  1 once the clear sequence is done (state RUN)
clr_idx  output  AW  current clear pointer (debug)
err_count  output  16  saturating count of out-of-window writes

Behaviour:
- Reset (reset_n=0, async): state=CLEAR, clr_idx=0, ready=0, insn_data=0, err_count=0, read-data register=0, read-hit flag=0, norm_data=z. RAM contents are not reset directly.
- Hit decode: a hit is norm_addr[31:AW]==BASE[31:AW]; the index is norm_addr[AW-1:0]. Fetches decode the same way on insn_addr.
- State CLEAR, on each posedge with en=1:
  - RAM[clr_idx] <= 0; clr_idx <= clr_idx+1.
  - When clr_idx==DEPTH-1 is written, go to RUN next cycle with ready=1 and clr_idx wrapped to 0.
  - Bus accesses are ignored: no writes, read-hit flag=0, insn_data=0.
  - err_count does not count.
- State RUN, on each posedge with en=1:
  - Write: rw=1 and hit -> RAM[idx] <= norm_data.
  - Stray write: rw=1 and miss -> err_count <= err_count+1, saturating at 16'hFFFF.
  - Read: rw=0 and hit -> read-data register <= RAM[idx] and read-hit flag=1. rw=0 and miss -> flag=0.
  - norm_data = flag ? read-data : 32'bz. It is stable from this posedge to the next, so Core samples it at the following negedge (half-cycle latency).
  - Fetch: insn_data <= hit ? RAM[idx] : 32'hFFFFFFFF. The all-ones word decodes as illegal in Core and halts it.
- Same-cycle fetch and data write to the same index: insn_data returns the OLD word (read-before-write); the new word is visible from the next cycle.
- Write at cycle N, read of the same address at N+1: returns the new word.
- Once in RUN, the block stays in RUN until reset. There is no other exit.
- reset_n asserted mid-clear or mid-run: immediate return to the reset state. The RAM is re-cleared from index 0 after release. Words not yet re-cleared keep stale data but are unreachable until ready=1.
- en=0 in any state: no RAM write, no counter or pointer advance. Registered outputs, including norm_data drive, hold.
- The block never drives norm_data while rw=1.

Test Plan:
- Release reset with DEPTH=16 and en=1 -> ready=0 for exactly 16 posedges, then ready=1. Reading each of 0x1000..0x100F returns 0; insn_data=0 throughout CLEAR.
- In RUN, write 0xDEADBEEF to 0x1005, then read 0x1005 next cycle -> norm_data=0xDEADBEEF after that posedge. With rw=0 and norm_addr=0 (idle) -> norm_data=z.
- Same cycle: insn_addr=0x1003 (holding 0x11111111) and a write of 0x22222222 to 0x1003 -> insn_data=0x11111111. A fetch of 0x1003 next cycle -> 0x22222222.
- insn_addr=0x2000 (out of window) -> insn_data=0xFFFFFFFF. 70000 writes to 0x0500 -> err_count=0xFFFF, and no RAM word changes.
- Write 0x5 to 0x1002, then pulse reset_n low for 1 ns after 8 clear cycles -> clr_idx=0 and ready=0 immediately. After 16 more cycles, ready=1 and 0x1002 reads 0.
- en=0 for 5 cycles during CLEAR at clr_idx=4 -> clr_idx stays 4 and ready stays low. ready rises 12 cycles after en returns high.

Source files
------------

// File: rtl/tenyr_mem_if.sv
// Core-side fetch and data-address bus seen by tenyr_mem_responder.
// The bidirectional norm_data lane is carried as a separate inout on the responder.
interface tenyr_mem_if;
    logic [31:0] insn_addr;
    logic [31:0] insn_data;
    logic        rw;
    logic [31:0] norm_addr;

    modport master (output insn_addr, input insn_data, output rw, output norm_addr);
    modport slave  (input insn_addr, output insn_data, input rw, input norm_addr);
endinterface

// File: rtl/tenyr_mem_responder.sv
// DEPTH-word RAM window at BASE answering Core fetches and data accesses.
// Clears itself after reset and counts writes that miss the window.
//
// state | meaning
// CLEAR | zeroing RAM[clr_idx] each enabled cycle, bus ignored, ready=0
// RUN   | serving fetches, reads and writes, ready=1 until reset
module tenyr_mem_responder #(
    parameter logic [31:0] BASE  = 32'h0000_1000,
    parameter int          DEPTH = 1024,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    tenyr_mem_if.slave    bus,
    inout  wire [31:0]    norm_data,
    output logic          ready,
    output logic [AW-1:0] clr_idx,
    output logic [15:0]   err_count
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];

    logic          d_hit, i_hit;
    logic [AW-1:0] d_idx, i_idx;

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    logic [AW-1:0] clr_nxt;
    logic [31:0]   insn_nxt;
    logic [31:0]   rd_data, rd_nxt;
    logic          rd_hit, rd_hit_nxt;
    logic [15:0]   err_nxt;

    assign d_hit = (bus.norm_addr[31:AW] == BASE[31:AW]);
    assign i_hit = (bus.insn_addr[31:AW] == BASE[31:AW]);
    assign d_idx = bus.norm_addr[AW-1:0];
    assign i_idx = bus.insn_addr[AW-1:0];

    assign ready = (state == RUN);

    // A write cycle drops the read-hit flag, and rw gates the driver so the
    // bus is never contended while Core drives write data.
    assign norm_data = (rd_hit && !bus.rw) ? rd_data : 32'bz;

    always_comb begin
        state_nxt  = state;
        clr_nxt    = clr_idx;
        mem_we     = 1'b0;
        mem_widx   = d_idx;
        mem_wdata  = norm_data;
        insn_nxt   = bus.insn_data;
        rd_nxt     = rd_data;
        rd_hit_nxt = rd_hit;
        err_nxt    = err_count;
        if (en) begin
            case (state)
                CLEAR: begin
                    mem_we     = 1'b1;
                    mem_widx   = clr_idx;
                    mem_wdata  = 32'h0;
                    clr_nxt    = clr_idx + 1'b1;
                    insn_nxt   = 32'h0;
                    rd_hit_nxt = 1'b0;
                    if (clr_idx == AW'(DEPTH - 1)) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    // Reads the pre-write word, so a same-cycle write to the
                    // fetched index shows up one cycle later.
                    insn_nxt = i_hit ? mem[i_idx] : 32'hFFFF_FFFF;
                    if (bus.rw) begin
                        rd_hit_nxt = 1'b0;
                        if (d_hit) begin
                            mem_we = 1'b1;
                        end else if (err_count != 16'hFFFF) begin
                            err_nxt = err_count + 16'd1;
                        end
                    end else begin
                        rd_hit_nxt = d_hit;
                        if (d_hit) begin
                            rd_nxt = mem[d_idx];
                        end
                    end
                end
                default: state_nxt = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= CLEAR;
            clr_idx       <= '0;
            bus.insn_data <= 32'h0;
            rd_data       <= 32'h0;
            rd_hit        <= 1'b0;
            err_count     <= 16'h0;
        end else begin
            state         <= state_nxt;
            clr_idx       <= clr_nxt;
            bus.insn_data <= insn_nxt;
            rd_data       <= rd_nxt;
            rd_hit        <= rd_hit_nxt;
            err_count     <= err_nxt;
        end
    end

    // RAM has no reset; the CLEAR sequence zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_tenyr_mem_responder.sv
// Self-checking bench for tenyr_mem_responder: vector table, hand sequences
// for clear/reset/enable corners, and random traffic against a word-array model.
`timescale 1ns/100ps
module tb_tenyr_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_wdata = 32'h0;
    wire  [31:0] norm_data;
    logic        ready;
    logic [3:0]  clr_idx;
    logic [15:0] err_count;

    tenyr_mem_if bus ();

    assign norm_data = tb_drv ? tb_wdata : 32'bz;

    tenyr_mem_responder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .bus       (bus),
        .norm_data (norm_data),
        .ready     (ready),
        .clr_idx   (clr_idx),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Behavioural model: word array plus expected registered outputs.
    logic [31:0] mdl [DEPTH];
    int          mdl_err;
    logic [31:0] exp_insn;
    logic        exp_drv;
    logic [31:0] exp_rd;

    typedef struct {
        logic        rw;
        logic [31:0] na;
        logic [31:0] wd;
        logic [31:0] ia;
        logic [31:0] exp_insn;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic rw, input logic [31:0] na, input logic [31:0] wd,
                                input logic [31:0] ia, input logic [31:0] ei, input logic cr,
                                input logic [31:0] er, input logic [15:0] ee);
        vec_t v;
        v.rw = rw; v.na = na; v.wd = wd; v.ia = ia;
        v.exp_insn = ei; v.chk_rd = cr; v.exp_rd = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a - BASE);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_undriven(input string name);
        total++;
        if (norm_data === 32'bz || norm_data === 32'h0) passed++;
        else $display("FAIL %s: norm_data got %h expected undriven", name, norm_data);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        mdl_err  = 0;
        exp_insn = 32'h0;
        exp_drv  = 1'b0;
        exp_rd   = 32'h0;
    endtask

    // Drive one cycle of traffic (RUN state), update the model, advance past the edge.
    task automatic step(input logic e, input logic r, input logic [31:0] na,
                        input logic [31:0] wd, input logic [31:0] ia);
        en = e; bus.rw = r; bus.norm_addr = na; bus.insn_addr = ia;
        tb_drv = r; tb_wdata = wd;
        if (e) begin
            exp_insn = in_win(ia) ? mdl[widx(ia)] : 32'hFFFF_FFFF;
            if (r) begin
                exp_drv = 1'b0;
                if (in_win(na)) mdl[widx(na)] = wd;
                else if (mdl_err < 65535) mdl_err++;
            end else begin
                exp_drv = in_win(na);
                if (exp_drv) exp_rd = mdl[widx(na)];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_insn"}, bus.insn_data, exp_insn);
        chk({tag, "_err"}, 32'(err_count), 32'(mdl_err));
        if (!bus.rw) begin
            if (exp_drv) chk({tag, "_rd"}, norm_data, exp_rd);
            else chk_undriven({tag, "_hiz"});
        end
    endtask

    task automatic go_idle();
        bus.rw = 1'b0; bus.norm_addr = 32'h0; tb_drv = 1'b0; bus.insn_addr = 32'h0;
    endtask

    initial begin
        logic [31:0] na, ia;
        logic        r, e;

        vecs[0] = mk(1'b1, 32'h1005, 32'hDEADBEEF, 32'h1000, 32'h0000_0000, 1'b0, 32'h0, 16'd0);
        vecs[1] = mk(1'b0, 32'h1005, 32'h0,       32'h1005, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 16'd0);
        vecs[2] = mk(1'b0, 32'h0000, 32'h0,       32'h1005, 32'hDEADBEEF, 1'b0, 32'h0, 16'd0);
        vecs[3] = mk(1'b1, 32'h1003, 32'h11111111, 32'h2000, 32'hFFFFFFFF, 1'b0, 32'h0, 16'd0);
        vecs[4] = mk(1'b1, 32'h1003, 32'h22222222, 32'h1003, 32'h11111111, 1'b0, 32'h0, 16'd0);
        vecs[5] = mk(1'b0, 32'h1003, 32'h0,       32'h1003, 32'h22222222, 1'b1, 32'h22222222, 16'd0);
        vecs[6] = mk(1'b1, 32'h0FFF, 32'hAAAA0001, 32'h1010, 32'hFFFFFFFF, 1'b0, 32'h0, 16'd1);
        vecs[7] = mk(1'b1, 32'h1010, 32'hAAAA0002, 32'h100F, 32'h0000_0000, 1'b0, 32'h0, 16'd2);
        vecs[8] = mk(1'b0, 32'h100F, 32'h0,       32'h0FFF, 32'hFFFFFFFF, 1'b1, 32'h0, 16'd2);
        vecs[9] = mk(1'b0, 32'h1000, 32'h0,       32'h1006, 32'h0000_0000, 1'b1, 32'h0, 16'd2);

        // Reset state, then the clear sequence with stray bus traffic that must be ignored.
        model_clear();
        bus.insn_addr = 32'h1000; bus.rw = 1'b0; bus.norm_addr = 32'h0;
        #12;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_clr_idx", 32'(clr_idx), 32'h0);
        chk("rst_insn", bus.insn_data, 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk_undriven("rst_hiz");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            bus.rw = 1'b1; tb_drv = 1'b1; tb_wdata = 32'h12345678;
            bus.norm_addr = (k % 2 == 1) ? (BASE + 32'(k - 1)) : 32'h0500;
            @(posedge clk);
            #1;
            chk("clr_ready", 32'(ready), (k == DEPTH) ? 32'h1 : 32'h0);
            chk("clr_idx", 32'(clr_idx), 32'(k % DEPTH));
            chk("clr_insn", bus.insn_data, 32'h0);
            chk("clr_err", 32'(err_count), 32'h0);
        end

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, BASE + 32'(i), 32'h0, BASE + 32'(i));
            check_model("clr_read");
        end

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].rw, vecs[i].na, vecs[i].wd, vecs[i].ia);
            chk("vec_insn", bus.insn_data, vecs[i].exp_insn);
            chk("vec_err", 32'(err_count), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) chk("vec_rd", norm_data, vecs[i].exp_rd);
            else if (!vecs[i].rw) chk_undriven("vec_hiz");
        end

        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 9) != 0);
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: na = 32'h0;
                1: na = BASE - 32'd1;
                2: na = BASE + DEPTH;
                3: na = $urandom;
                default: na = BASE + 32'($urandom_range(0, DEPTH - 1));
            endcase
            ia = ($urandom_range(0, 9) < 7) ? BASE + 32'($urandom_range(0, DEPTH - 1)) : $urandom;
            step(e, r, na, $urandom, ia);
            check_model("rand");
        end

        // Error counter saturation; misses must not disturb any RAM word.
        for (int n = 0; n < 70000; n++) step(1'b1, 1'b1, 32'h0500, $urandom, 32'h2000);
        chk("sat_err", 32'(err_count), 32'h0000_FFFF);
        chk("sat_insn", bus.insn_data, 32'hFFFF_FFFF);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, BASE + 32'(i), 32'h0, BASE + 32'(i));
            check_model("sat_read");
        end

        // Reset pulse in the middle of a clear sequence.
        step(1'b1, 1'b1, 32'h1002, 32'h5, 32'h0);
        go_idle();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("rst2_ready", 32'(ready), 32'h0);
        chk("rst2_err", 32'(err_count), 32'h0);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_clr_idx", 32'(clr_idx), 32'h8);
        @(negedge clk);
        reset_n = 1'b0;
        #0.5;
        chk("pulse_clr_idx", 32'(clr_idx), 32'h0);
        chk("pulse_ready", 32'(ready), 32'h0);
        #0.5;
        reset_n = 1'b1;
        repeat (DEPTH - 1) @(posedge clk);
        #1;
        chk("reclr_ready_lo", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        chk("reclr_ready_hi", 32'(ready), 32'h1);
        model_clear();
        step(1'b1, 1'b0, 32'h1002, 32'h0, 32'h1002);
        check_model("reclr_read");

        // Enable held low for five cycles partway through clear.
        go_idle();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("en_clr_idx4", 32'(clr_idx), 32'h4);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("en_hold_idx", 32'(clr_idx), 32'h4);
            chk("en_hold_ready", 32'(ready), 32'h0);
        end
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            chk("en_resume_ready", 32'(ready), (k == 12) ? 32'h1 : 32'h0);
        end
        model_clear();
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, DEPTH - 1)),
                 $urandom, BASE + 32'($urandom_range(0, DEPTH - 1)));
            check_model("post_en");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
